// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer and its synchronizer.
package pll_seq_pkg;

    localparam int STATE_W = 3;
    localparam int LOL_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } seq_state_t;

    // Sizes the shared phase counter so it can reach the longest of the three phases.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_locked_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into the refclk domain.
module pll_locked_sync (
    input  logic refclk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge refclk) begin
        if (rst) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulse PLL reset, wait for lock with timeout/retry, qualify stability, release sys_rst.
// Optional build macro PLL_SEQ_LOL_COUNT_EN adds the saturating loss-of-lock counter output lol_count.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int  RST_PULSE_CYCLES    = 16,
    parameter int  LOCK_TIMEOUT_CYCLES = 50000,
    parameter int  LOCK_STABLE_CYCLES  = 1024,
    parameter int  MAX_RETRIES         = 3,
    localparam int RW                  = $clog2(MAX_RETRIES + 1)
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               retry_req,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fault,
    output logic [RW-1:0]      retry_cnt,
    output logic [STATE_W-1:0] state_o
`ifdef PLL_SEQ_LOL_COUNT_EN
    ,
    output logic [LOL_W-1:0]   lol_count
`endif
);

    localparam int CW = $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)) + 1;

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    seq_state_t     state;
    seq_state_t     nxt_state;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  nxt_cnt;
    logic [RW-1:0]  nxt_retry;
    logic           locked_s;

    pll_locked_sync u_sync (
        .refclk   (refclk),
        .rst      (rst),
        .async_in (pll_locked),
        .sync_out (locked_s)
    );

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_retry = retry_cnt;
        case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    nxt_state = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle still counts as a successful attempt.
                if (locked_s) begin
                    nxt_state = STABILIZE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_cnt == RETRY_MAX) begin
                        nxt_state = FAULT;
                    end else begin
                        nxt_state = RESET_PLL;
                        nxt_retry = retry_cnt + 1'b1;
                    end
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    nxt_state = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    nxt_state = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    nxt_state = RESET_PLL;
                    nxt_retry = '0;
                end
            end
            FAULT: begin
                nxt_retry = RETRY_MAX;
                if (retry_req) begin
                    nxt_state = RESET_PLL;
                    nxt_retry = '0;
                end
            end
            default: begin
                nxt_state = RESET_PLL;
                nxt_retry = '0;
            end
        endcase

        // Only the timed phases count; RUN and FAULT hold so the counter can never wrap.
        if (nxt_state != state) begin
            nxt_cnt = '0;
        end else if (state == RESET_PLL || state == WAIT_LOCK || state == STABILIZE) begin
            nxt_cnt = cnt + 1'b1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            retry_cnt <= nxt_retry;
            pll_rst   <= (nxt_state == RESET_PLL) || (nxt_state == FAULT);
            sys_rst   <= (nxt_state != RUN);
            ready     <= (nxt_state == RUN);
            fault     <= (nxt_state == FAULT);
        end
    end

    assign state_o = state;

`ifdef PLL_SEQ_LOL_COUNT_EN
    always_ff @(posedge refclk) begin
        if (rst) begin
            lol_count <= '0;
        end else if (state == RUN && !locked_s && lol_count != '1) begin
            lol_count <= lol_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer with shortened timing parameters and hand-timed directed vectors.
module tb_pll_lock_sequencer;
    import pll_seq_pkg::*;

    localparam int RW = 2;

    logic refclk = 1'b0;
    logic rst;
    logic pll_locked;
    logic retry_req;
    logic pll_rst;
    logic sys_rst;
    logic ready;
    logic fault;
    logic [RW-1:0] retry_cnt;
    logic [STATE_W-1:0] state_o;
`ifdef PLL_SEQ_LOL_COUNT_EN
    logic [LOL_W-1:0] lol_count;
`endif

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         at_cyc;
        string      name;
        logic [2:0] st;
        logic       pr;
        logic       sr;
        logic       rdy;
        logic       flt;
        logic [1:0] rc;
        logic [7:0] lol;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .retry_req  (retry_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .state_o    (state_o)
`ifdef PLL_SEQ_LOL_COUNT_EN
        ,
        .lol_count  (lol_count)
`endif
    );

    always #5 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    task automatic waitUntil(input int n);
        while (cyc < n) @(negedge refclk);
    endtask

    task automatic applyStimulus(input int at, input logic r, input logic lk, input logic rq);
        waitUntil(at);
        rst        = r;
        pll_locked = lk;
        retry_req  = rq;
    endtask

    task automatic pushExp(input int at, input string nm, input logic [2:0] st, input logic pr,
                           input logic sr, input logic rdy, input logic flt, input logic [1:0] rc,
                           input logic [7:0] lol);
        exp_t e;
        e.at_cyc = at; e.name = nm; e.st = st; e.pr = pr; e.sr = sr;
        e.rdy = rdy; e.flt = flt; e.rc = rc; e.lol = lol;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        vectors++;
        if (e.at_cyc != cyc || state_o !== e.st || pll_rst !== e.pr || sys_rst !== e.sr ||
            ready !== e.rdy || fault !== e.flt || retry_cnt !== e.rc) begin
            miscompares++;
            $display("[TB] FAIL %s @cyc %0d: got st=%0d pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d, expected @cyc %0d st=%0d pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d",
                     e.name, cyc, state_o, pll_rst, sys_rst, ready, fault, retry_cnt,
                     e.at_cyc, e.st, e.pr, e.sr, e.rdy, e.flt, e.rc);
        end
`ifdef PLL_SEQ_LOL_COUNT_EN
        vectors++;
        if (lol_count !== e.lol) begin
            miscompares++;
            $display("[TB] FAIL %s_lol @cyc %0d: got lol_count=%0d, expected %0d", e.name, cyc, lol_count, e.lol);
        end
`endif
    endtask

    always @(negedge refclk) begin
        while (exp_q.size() > 0 && exp_q[0].at_cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            checkOutput(mon_e);
        end
    end

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        retry_req  = 1'b0;

        // Bring-up: reset for 3 edges, lock arrives shortly after release.
        pushExp(1,  "reset_state",     RESET_PLL, 1, 1, 0, 0, 0, 0);
        pushExp(4,  "pulse_start",     RESET_PLL, 1, 1, 0, 0, 0, 0);
        pushExp(6,  "pulse_last",      RESET_PLL, 1, 1, 0, 0, 0, 0);
        pushExp(7,  "wait_lock",       WAIT_LOCK, 0, 1, 0, 0, 0, 0);
        pushExp(8,  "stabilize_entry", STABILIZE, 0, 1, 0, 0, 0, 0);
        pushExp(15, "stabilize_last",  STABILIZE, 0, 1, 0, 0, 0, 0);
        pushExp(16, "run_entry",       RUN,       0, 0, 1, 0, 0, 0);
        applyStimulus(3, 0, 0, 0);
        applyStimulus(4, 0, 1, 0);

        // Loss of lock in RUN, then three failed attempts into FAULT.
        pushExp(22, "run_hold",          RUN,       0, 0, 1, 0, 0, 0);
        pushExp(23, "lol_exit",          RESET_PLL, 1, 1, 0, 0, 0, 1);
        pushExp(26, "att1_pulse",        RESET_PLL, 1, 1, 0, 0, 0, 1);
        pushExp(27, "att1_wait",         WAIT_LOCK, 0, 1, 0, 0, 0, 1);
        pushExp(31, "retry_req_ignored", WAIT_LOCK, 0, 1, 0, 0, 0, 1);
        pushExp(46, "att1_last",         WAIT_LOCK, 0, 1, 0, 0, 0, 1);
        pushExp(47, "att2_pulse",        RESET_PLL, 1, 1, 0, 0, 1, 1);
        pushExp(51, "att2_wait",         WAIT_LOCK, 0, 1, 0, 0, 1, 1);
        pushExp(71, "att3_pulse",        RESET_PLL, 1, 1, 0, 0, 2, 1);
        pushExp(94, "att3_last",         WAIT_LOCK, 0, 1, 0, 0, 2, 1);
        pushExp(95, "fault_entry",       FAULT,     1, 1, 0, 1, 2, 1);
        pushExp(100, "fault_hold",       FAULT,     1, 1, 0, 1, 2, 1);
        applyStimulus(20, 0, 0, 0);
        applyStimulus(30, 0, 0, 1);
        applyStimulus(31, 0, 0, 0);

        // Recovery from FAULT via retry_req.
        pushExp(101, "fault_retry",     RESET_PLL, 1, 1, 0, 0, 0, 1);
        pushExp(105, "retry_wait",      WAIT_LOCK, 0, 1, 0, 0, 0, 1);
        pushExp(106, "retry_stab",      STABILIZE, 0, 1, 0, 0, 0, 1);
        pushExp(113, "retry_stab_last", STABILIZE, 0, 1, 0, 0, 0, 1);
        pushExp(114, "retry_run",       RUN,       0, 0, 1, 0, 0, 1);
        applyStimulus(100, 0, 1, 1);
        applyStimulus(101, 0, 1, 0);

        // One timeout, then a one-cycle lock glitch at stable count 5.
        pushExp(123, "lol2_exit",       RESET_PLL, 1, 1, 0, 0, 0, 2);
        pushExp(146, "s4_wait_last",    WAIT_LOCK, 0, 1, 0, 0, 0, 2);
        pushExp(147, "s4_retry",        RESET_PLL, 1, 1, 0, 0, 1, 2);
        pushExp(151, "s4_wait",         WAIT_LOCK, 0, 1, 0, 0, 1, 2);
        pushExp(152, "s4_stab",         STABILIZE, 0, 1, 0, 0, 1, 2);
        pushExp(157, "s4_stab5",        STABILIZE, 0, 1, 0, 0, 1, 2);
        pushExp(158, "s4_glitch",       WAIT_LOCK, 0, 1, 0, 0, 1, 2);
        pushExp(159, "s4_restab",       STABILIZE, 0, 1, 0, 0, 1, 2);
        pushExp(160, "s4_no_early_run", STABILIZE, 0, 1, 0, 0, 1, 2);
        pushExp(166, "s4_stab_last",    STABILIZE, 0, 1, 0, 0, 1, 2);
        pushExp(167, "s4_run",          RUN,       0, 0, 1, 0, 1, 2);
        applyStimulus(120, 0, 0, 0);
        applyStimulus(145, 0, 1, 0);
        applyStimulus(155, 0, 0, 0);
        applyStimulus(156, 0, 1, 0);

        // Lock lost, one retry consumed, then rst asserted in WAIT_LOCK at count 10.
        pushExp(172, "s6_run",        RUN,       0, 0, 1, 0, 1, 2);
        pushExp(173, "s6_lol",        RESET_PLL, 1, 1, 0, 0, 0, 3);
        pushExp(197, "s6_retry",      RESET_PLL, 1, 1, 0, 0, 1, 3);
        pushExp(211, "s6_wait10",     WAIT_LOCK, 0, 1, 0, 0, 1, 3);
        pushExp(212, "s6_reset",      RESET_PLL, 1, 1, 0, 0, 0, 0);
        pushExp(213, "s6_reset_hold", RESET_PLL, 1, 1, 0, 0, 0, 0);
        applyStimulus(170, 0, 0, 0);
        applyStimulus(211, 1, 0, 0);

        // Lock arriving on the timeout cycle wins over the retry.
        pushExp(216, "s7_pulse_last", RESET_PLL, 1, 1, 0, 0, 0, 0);
        pushExp(217, "s7_wait",       WAIT_LOCK, 0, 1, 0, 0, 0, 0);
        pushExp(236, "s7_wait_last",  WAIT_LOCK, 0, 1, 0, 0, 0, 0);
        pushExp(237, "s7_lock_wins",  STABILIZE, 0, 1, 0, 0, 0, 0);
        pushExp(245, "s7_run",        RUN,       0, 0, 1, 0, 0, 0);
        applyStimulus(213, 0, 0, 0);
        applyStimulus(234, 0, 1, 0);

        waitUntil(250);
        repeat (3) @(negedge refclk);
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: expectation for cyc %0d never checked, now cyc %0d", mon_e.name, mon_e.at_cyc, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
